// File: rtl/scr_pkg.sv
// Shared state encoding and scrambler constants for the frame sequencer.
// The scrambler itself lives outside this block; only its seed and taps are recorded here.
package scr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    PRE,
    PAY,
    TAIL
  } state_t;

  localparam logic [6:0] SCR_SEED  = 7'b1010000;
  localparam int         SCR_TAP_A = 6;
  localparam int         SCR_TAP_B = 3;

endpackage

// File: rtl/scrambler_frame_ctrl_if.sv
// Payload byte stream from the MAC side: valid/ready handshake with end-of-frame marker.
interface scrambler_frame_ctrl_if;

  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);

endinterface

// File: rtl/scr_byte_serializer.sv
// One-byte holding register feeding an 8-bit LSB-first shifter; flags an empty hold at a byte boundary.
// Bytes are accepted only while enabled, the hold is empty and no last byte has been taken this frame.
module scr_byte_serializer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       rx_en,
  input  logic       boundary,
  input  logic       shift_en,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       cur_bit,
  output logic       byte_end,
  output logic       cur_last,
  output logic       underrun
);

  logic [7:0] hold_data;
  logic [7:0] shift_data;
  logic       hold_full;
  logic       hold_last;
  logic       last_taken;
  logic       shift_last;
  logic [2:0] bit_cnt;
  logic       accept;
  logic       load;

  assign s_ready  = rx_en & ~hold_full & ~last_taken;
  assign accept   = s_valid & s_ready;
  assign load     = boundary & hold_full;
  assign underrun = boundary & ~hold_full;
  assign cur_bit  = shift_data[0];
  assign byte_end = (bit_cnt == 3'd7);
  assign cur_last = shift_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hold_data  <= '0;
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      last_taken <= 1'b0;
      shift_data <= '0;
      shift_last <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      if (accept) begin
        hold_data <= s_data;
        hold_last <= s_last;
      end
      // A load empties the hold; a refill can only land once it is empty again.
      hold_full <= (hold_full & ~load) | accept;
      if (accept && s_last) begin
        last_taken <= 1'b1;
      end
      if (load) begin
        shift_data <= hold_data;
        shift_last <= hold_last;
        bit_cnt    <= '0;
      end else if (shift_en) begin
        shift_data <= {1'b0, shift_data[7:1]};
        bit_cnt    <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer: seed strobe, alternating preamble, LSB-first payload, zero flush tail.
// First frame bit two cycles after start; payload backpressured through a single holding byte.
module scrambler_frame_ctrl
  import scr_pkg::*;
#(
  parameter int PRE_LEN  = 16,
  parameter int TAIL_LEN = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  scrambler_frame_ctrl_if.slave       s,
  output logic                        scr_reset,
  output logic                        scr_bit_in,
  input  logic                        scr_bit_out,
  output logic                        tx_bit,
  output logic                        tx_valid,
  output logic                        tx_sof,
  output logic                        tx_eof,
  output logic                        err_underrun,
  output logic [15:0]                 frame_count
);

  localparam logic [7:0] PRE_LAST  = 8'(PRE_LEN - 1);
  localparam logic [7:0] TAIL_LAST = 8'(TAIL_LEN - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] phase;
  logic [7:0] phase_nxt;
  logic       pre_end;
  logic       tail_end;
  logic       boundary;
  logic       rx_en;
  logic       start_ok;
  logic       cur_bit;
  logic       byte_end;
  logic       cur_last;
  logic       underrun;

  assign pre_end  = (state == PRE) && (phase == PRE_LAST);
  assign tail_end = (state == TAIL) && (phase == TAIL_LAST);
  // Transfer points: entering payload, and each byte end unless that byte closed the frame.
  assign boundary = pre_end | ((state == PAY) & byte_end & ~cur_last);
  assign rx_en    = (state == SEED) | (state == PRE) | (state == PAY);
  assign start_ok = (state == IDLE) & start;
  assign tx_bit   = scr_bit_out;

  scr_byte_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .rx_en    (rx_en),
    .boundary (boundary),
    .shift_en (state == PAY),
    .s_valid  (s.valid),
    .s_data   (s.data),
    .s_last   (s.last),
    .s_ready  (s.ready),
    .cur_bit  (cur_bit),
    .byte_end (byte_end),
    .cur_last (cur_last),
    .underrun (underrun)
  );

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    busy       = 1'b1;
    scr_reset  = 1'b0;
    scr_bit_in = 1'b0;
    tx_valid   = 1'b0;
    tx_sof     = 1'b0;
    tx_eof     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = SEED;
          phase_nxt = '0;
        end
      end
      SEED: begin
        scr_reset = 1'b1;
        state_nxt = PRE;
        phase_nxt = '0;
      end
      PRE: begin
        tx_valid   = 1'b1;
        tx_sof     = (phase == 8'd0);
        scr_bit_in = ~phase[0];
        if (pre_end) begin
          state_nxt = underrun ? TAIL : PAY;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 8'd1;
        end
      end
      PAY: begin
        tx_valid   = 1'b1;
        scr_bit_in = cur_bit;
        if (byte_end && (cur_last || underrun)) begin
          state_nxt = TAIL;
          phase_nxt = '0;
        end
      end
      TAIL: begin
        tx_valid = 1'b1;
        tx_eof   = tail_end;
        if (tail_end) begin
          state_nxt = IDLE;
        end else begin
          phase_nxt = phase + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      err_underrun <= 1'b0;
      frame_count  <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (start_ok) begin
        err_underrun <= 1'b0;
      end else if (underrun) begin
        err_underrun <= 1'b1;
      end
      if (tail_end) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// Bench for scrambler_frame_ctrl: external scrambler model, frame-level reference model and
// a scoreboard queue of expected line bits drained by an independent monitor.
module tb_scrambler_frame_ctrl;
  import scr_pkg::*;

  localparam int PRE_LEN  = 16;
  localparam int TAIL_LEN = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        scr_reset;
  logic        scr_bit_in;
  logic        scr_bit_out;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_sof;
  logic        tx_eof;
  logic        err_underrun;
  logic [15:0] frame_count;
  logic [6:0]  scr_s = '0;

  scrambler_frame_ctrl_if s_if();

  always #5 clk = ~clk;

  scrambler_frame_ctrl #(.PRE_LEN(PRE_LEN), .TAIL_LEN(TAIL_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .s            (s_if),
    .scr_reset    (scr_reset),
    .scr_bit_in   (scr_bit_in),
    .scr_bit_out  (scr_bit_out),
    .tx_bit       (tx_bit),
    .tx_valid     (tx_valid),
    .tx_sof       (tx_sof),
    .tx_eof       (tx_eof),
    .err_underrun (err_underrun),
    .frame_count  (frame_count)
  );

  // Line-side self-synchronising scrambler the sequencer drives.
  assign scr_bit_out = scr_bit_in ^ scr_s[6] ^ scr_s[3];
  always @(posedge clk) scr_s <= scr_reset ? SCR_SEED : {scr_s[5:0], scr_bit_out};

  typedef struct {
    logic        b;
    logic        sof;
    logic        eof;
    logic        err;
    logic [15:0] fc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  frame_bytes[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_fc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: build the frame's plain bit list, then scramble it as a sequence where each
  // output bit is the input xor the outputs 7 and 4 positions earlier (seed supplies history).
  task automatic push_expected(input int nb, input logic err, input logic [15:0] fc);
    bit         inb[$];
    bit         hist[$];
    logic [6:0] seed;
    logic [7:0] by;
    exp_t       e;
    bit         o;
    for (int i = 0; i < PRE_LEN; i++) inb.push_back((i % 2) == 0);
    for (int k = 0; k < nb; k++) begin
      by = frame_bytes[k];
      for (int b = 0; b < 8; b++) inb.push_back(by[b]);
    end
    for (int i = 0; i < TAIL_LEN; i++) inb.push_back(1'b0);
    seed = SCR_SEED;
    for (int i = 6; i >= 0; i--) hist.push_back(seed[i]);
    for (int i = 0; i < inb.size(); i++) begin
      o = inb[i] ^ hist[hist.size() - 7] ^ hist[hist.size() - 4];
      hist.push_back(o);
      e.b   = o;
      e.sof = (i == 0);
      e.eof = (i == inb.size() - 1);
      e.err = err;
      e.fc  = fc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    if (busy) fail_timeout("wait_idle");
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int n = 0;
    s_if.valid = 1'b0;
    repeat (gap) tick();
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = last;
    while (!s_if.ready && n < 500) begin
      tick();
      n++;
    end
    if (!s_if.ready) begin
      fail_timeout("byte_accept");
      s_if.valid = 1'b0;
      return;
    end
    tick();
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic do_frame(input int nb, input bit underrun, input bit extra_start, input int max_gap);
    int npay;
    int n;
    npay = underrun ? 1 : nb;
    wait_idle();
    exp_fc++;
    push_expected(npay, underrun, exp_fc);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("seed_scr_reset", scr_reset, 1);
    check("seed_tx_valid", tx_valid, 0);
    check("seed_busy", busy, 1);
    check("err_clear_on_start", err_underrun, 0);
    fork
      begin
        tick();
        check("pre_scr_reset", scr_reset, 0);
        check("sof_latency", tx_sof & tx_valid, 1);
      end
      begin
        for (int k = 0; k < npay; k++)
          send_byte(frame_bytes[k], !underrun && (k == npay - 1), $urandom_range(0, max_gap));
      end
      begin
        if (extra_start) begin
          repeat (26) tick();
          start = 1'b1;
          tick();
          start = 1'b0;
        end
      end
    join
    if (extra_start) begin
      n = 0;
      while (!tx_eof && n < 2000) begin
        tick();
        n++;
      end
      if (!tx_eof) fail_timeout("wait_eof");
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_idle();
    if (underrun) check("underrun_sticky", err_underrun, 1);
  endtask

  // Monitor: every frame bit is popped from the scoreboard and compared.
  exp_t        mon_e;
  logic        mon_fc_pending = 1'b0;
  logic [15:0] mon_fc_exp = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_fc_pending) begin
        mon_fc_pending = 1'b0;
        check("busy_after_eof", busy, 0);
        check("frame_count_after_eof", frame_count, mon_fc_exp);
      end
      if (tx_valid) begin
        check("busy_in_frame", busy, 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bit actual=tx_valid required=idle t=%0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_bit", tx_bit, mon_e.b);
          check("tx_sof", tx_sof, mon_e.sof);
          check("tx_eof", tx_eof, mon_e.eof);
          if (mon_e.eof) begin
            check("err_underrun_at_eof", err_underrun, mon_e.err);
            check("frame_count_at_eof", frame_count, mon_e.fc - 16'd1);
            mon_fc_pending = 1'b1;
            mon_fc_exp     = mon_e.fc;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("idle_tx_valid", tx_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_s_ready", s_if.ready, 0);
    check("idle_scr_reset", scr_reset, 0);
    check("idle_scr_bit_in", scr_bit_in, 0);
    check("idle_err", err_underrun, 0);
    check("idle_frame_count", frame_count, 0);

    // Reset in the middle of the payload: partial frame dropped and not counted.
    frame_bytes.delete();
    frame_bytes.push_back(8'h11);
    frame_bytes.push_back(8'h22);
    frame_bytes.push_back(8'h33);
    push_expected(3, 1'b0, exp_fc);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b1, 0);
    repeat (2) tick();
    check("mid_frame_valid", tx_valid, 1);
    reset = 1'b1;
    tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_if.ready, 0);
    check("rst_scr_reset", scr_reset, 0);
    check("rst_scr_bit_in", scr_bit_in, 0);
    check("rst_tx_sof", tx_sof, 0);
    check("rst_tx_eof", tx_eof, 0);
    check("rst_err", err_underrun, 0);
    check("rst_frame_count", frame_count, exp_fc);
    reset = 1'b0;
    exp_q.delete();
    repeat (5) tick();

    frame_bytes.delete();
    frame_bytes.push_back(8'hA5);
    do_frame(1, 1'b0, 1'b0, 0);

    frame_bytes.delete();
    for (int i = 1; i <= 4; i++) frame_bytes.push_back(8'(i));
    do_frame(4, 1'b0, 1'b0, 0);

    frame_bytes.delete();
    frame_bytes.push_back(8'h5C);
    frame_bytes.push_back(8'h77);
    do_frame(2, 1'b1, 1'b0, 3);

    frame_bytes.delete();
    frame_bytes.push_back(8'h3C);
    frame_bytes.push_back(8'hC3);
    do_frame(2, 1'b0, 1'b1, 0);

    for (int f = 0; f < 6; f++) begin
      int nb;
      nb = $urandom_range(1, 5);
      frame_bytes.delete();
      for (int i = 0; i < nb; i++) frame_bytes.push_back(8'($urandom_range(0, 255)));
      do_frame(nb, 1'b0, 1'b0, 3);
    end

    repeat (40) tick();
    check("queue_drained", exp_q.size(), 0);
    check("final_frame_count", frame_count, exp_fc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
